// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the 640x480 @ 60 Hz pixel pipeline.
// The frame size used by img_generator (FRAME_WIDTH/FRAME_HEIGHT) lives here
// next to the porch/sync values so the two sides of the pixel interface
// cannot drift apart.
// Optional feature macro: VGA_TEST_PATTERN_EN (built-in colour bars).
package vga_timing_pkg;

  localparam int unsigned CNT_W   = 10;  // wide enough for 0..799
  localparam int unsigned COORD_W = 12;  // x/y width toward img_generator
  localparam int unsigned COLOR_W = 3;

  // Horizontal timing, in pixels.
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FRONT_DEF  = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BACK_DEF   = 48;

  // Vertical timing, in lines.
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FRONT_DEF  = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BACK_DEF   = 33;

  // Visible frame seen by the image generator; equals the active region.
  localparam int unsigned FRAME_WIDTH  = H_ACTIVE_DEF;
  localparam int unsigned FRAME_HEIGHT = V_ACTIVE_DEF;

  typedef logic [COLOR_W-1:0] color_t;

  // Full period of one axis (active + front porch + sync + back porch).
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: a wrapping position counter with active-region and
// active-low sync decodes. Used once per line (horizontal) and once per
// frame (vertical, advanced by the horizontal wrap).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL  = 800,
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FRONT  = 16,
  parameter int unsigned SYNC   = 96
) (
  input  logic             CLOCK_25,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             active,
  output logic             sync_n,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FRONT + SYNC);

  // Position counter: advances on inc, wraps from TOTAL-1 back to 0.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign wrap   = inc && (cnt == LAST);
  assign active = (cnt < ACT_END);
  assign sync_n = !((cnt >= SYNC_START) && (cnt < SYNC_END));

endmodule

// File: rtl/vga_timing.sv
// VGA 640x480 @ 60 Hz timing generator and pixel-interface consumer.
// Stage 0: h/v counters plus combinational x/y toward img_generator.
// Stage 1: sync, de, rgb and frame_start registered together so they leave
// the block mutually aligned, one cycle after the x/y they belong to.
// Optional feature macro: VGA_TEST_PATTERN_EN -- when defined, test_pattern=1
// replaces color with eight 64-pixel colour bars taken from h_cnt[8:6].
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT  = H_FRONT_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BACK   = H_BACK_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FRONT  = V_FRONT_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BACK   = V_BACK_DEF
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic [COLOR_W-1:0] color,
  input  logic               test_pattern,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] rgb,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_act, v_act, hs0, vs0, h_wrap, v_wrap_unused;
  logic             act0;
  color_t           pix_color;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .ACTIVE(H_ACTIVE),
    .FRONT (H_FRONT),
    .SYNC  (H_SYNC)
  ) u_h_axis (
    .CLOCK_25(CLOCK_25),
    .reset   (reset),
    .inc     (1'b1),
    .cnt     (h_cnt),
    .active  (h_act),
    .sync_n  (hs0),
    .wrap    (h_wrap)
  );

  // The vertical axis steps once per line, on the edge the line wraps.
  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .ACTIVE(V_ACTIVE),
    .FRONT (V_FRONT),
    .SYNC  (V_SYNC)
  ) u_v_axis (
    .CLOCK_25(CLOCK_25),
    .reset   (reset),
    .inc     (h_wrap),
    .cnt     (v_cnt),
    .active  (v_act),
    .sync_n  (vs0),
    .wrap    (v_wrap_unused)
  );

  assign act0 = h_act && v_act;

  // 1-based coordinates during active video, 0 in blanking.
  assign x = act0 ? COORD_W'(h_cnt) + COORD_W'(1) : '0;
  assign y = act0 ? COORD_W'(v_cnt) + COORD_W'(1) : '0;

`ifdef VGA_TEST_PATTERN_EN
  assign pix_color = test_pattern ? color_t'(h_cnt[8:6]) : color;
`else
  logic unused_test_pattern;
  assign unused_test_pattern = test_pattern;
  assign pix_color           = color;
`endif

  // Stage-1 output register: everything leaving the block is captured here
  // together; reset parks the syncs inactive and blanks the pixel path.
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs0;
      vsync       <= vs0;
      de          <= act0;
      rgb         <= act0 ? pix_color : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing. Horizontal timing is the real 800-pixel
// line; the vertical axis is shortened to 8 lines (4 active, 1 front,
// 2 sync, 1 back) so two full frames fit in a short run.
module tb_vga_timing;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 4,   VF = 1,  VS = 2,  VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 800
  localparam int VT = VA + VF + VS + VB;  // 8
  localparam int FRAME = HT * VT;         // 6400

  typedef struct packed {
    logic [2:0]  rgb;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic [11:0] x;
    logic [11:0] y;
  } obs_t;

  logic        CLOCK_25 = 1'b0;
  logic        reset;
  logic [2:0]  color;
  logic        test_pattern;
  logic [11:0] x, y;
  logic        hsync, vsync, de, frame_start;
  logic [2:0]  rgb;

  logic white;  // 1: color = 3'b111, 0: color = x[2:0]

  int n_vec = 0;
  int n_err = 0;
  int hm = 0, vm = 0;  // model counters for the pixel currently presented
  int cyc = 0;

  vga_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .CLOCK_25   (CLOCK_25),
    .reset      (reset),
    .color      (color),
    .test_pattern(test_pattern),
    .x          (x),
    .y          (y),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .rgb        (rgb),
    .frame_start(frame_start)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  // The image generator stand-in: combinational colour from the coordinates.
  assign color = white ? 3'b111 : x[2:0];

  function automatic obs_t sample();
    obs_t o;
    o.rgb = rgb; o.de = de; o.hsync = hsync; o.vsync = vsync;
    o.frame_start = frame_start; o.x = x; o.y = y;
    return o;
  endfunction

  // Expected stage-1 outputs for the pixel at (hm,vm), then advance the
  // counters and return the x/y now presented for the next pixel.
  task automatic model_step(input logic wht, input logic tp, output obs_t e);
    logic       act;
    logic [9:0] h10;
    logic [2:0] pix;
    act = (hm < HA) && (vm < VA);
    h10 = 10'(hm);
    e.de          = act;
    e.hsync       = !((hm >= HA + HF) && (hm < HA + HF + HS));
    e.vsync       = !((vm >= VA + VF) && (vm < VA + VF + VS));
    e.frame_start = (hm == 0) && (vm == 0);
    pix = wht ? 3'b111 : 3'((hm + 1) % 8);
`ifdef VGA_TEST_PATTERN_EN
    if (tp) pix = h10[8:6];
`else
    if (tp) pix = pix;  // test_pattern must not change anything
`endif
    e.rgb = act ? pix : 3'b000;
    if (hm == HT - 1) begin
      hm = 0;
      vm = (vm == VT - 1) ? 0 : vm + 1;
    end else begin
      hm = hm + 1;
    end
    e.x = ((hm < HA) && (vm < VA)) ? 12'(hm + 1) : 12'd0;
    e.y = ((hm < HA) && (vm < VA)) ? 12'(vm + 1) : 12'd0;
  endtask

  task automatic report(input string name, input obs_t got, input obs_t exp);
    $display("FAIL %s cyc=%0d got rgb=%0d de=%0b hs=%0b vs=%0b fs=%0b x=%0d y=%0d want rgb=%0d de=%0b hs=%0b vs=%0b fs=%0b x=%0d y=%0d",
             name, cyc, got.rgb, got.de, got.hsync, got.vsync, got.frame_start, got.x, got.y,
             exp.rgb, exp.de, exp.hsync, exp.vsync, exp.frame_start, exp.x, exp.y);
  endtask

  task automatic test_reset();
    obs_t exp, got;
    exp = '{rgb: 3'd0, de: 1'b0, hsync: 1'b1, vsync: 1'b1, frame_start: 1'b0,
            x: 12'd1, y: 12'd1};
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLOCK_25);
      @(negedge CLOCK_25);
      got = sample();
      n_vec++;
      if (got !== exp) begin
        report("reset_defaults", got, exp);
        n_err++;
      end
    end
  endtask

  // Frame 1 with color = x[2:0]: per-pixel model plus sync/de measurements.
  task automatic test_timing_colour();
    obs_t exp, got;
    int   hs_run = 0, vs_run = 0, de_rise = 0, fs_count = 0;
    logic armed = 1'b0, prev_de = 1'b0, prev_hs = 1'b1;
    white = 1'b0;
    reset = 1'b0;
    hm = 0; vm = 0; cyc = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge CLOCK_25);
      @(negedge CLOCK_25);
      cyc++;
      got = sample();
      model_step(1'b0, 1'b0, exp);
      n_vec++;
      if (got !== exp) begin
        report("pixel_colour", got, exp);
        n_err++;
      end
      if (got.frame_start) fs_count++;
      if (got.de && !prev_de) begin
        de_rise = cyc;
        armed   = 1'b1;
      end
      if (!got.hsync && prev_hs && armed) begin
        n_vec++;
        if (cyc - de_rise !== 656) begin
          $display("FAIL hsync_offset got %0d want 656", cyc - de_rise);
          n_err++;
        end
        armed = 1'b0;
      end
      if (!got.hsync) hs_run++;
      else if (hs_run > 0) begin
        n_vec++;
        if (hs_run !== 96) begin
          $display("FAIL hsync_width got %0d want 96", hs_run);
          n_err++;
        end
        hs_run = 0;
      end
      if (!got.vsync) vs_run++;
      else if (vs_run > 0) begin
        n_vec++;
        if (vs_run !== VS * HT) begin
          $display("FAIL vsync_width got %0d want %0d", vs_run, VS * HT);
          n_err++;
        end
        vs_run = 0;
      end
      prev_de = got.de;
      prev_hs = got.hsync;
    end
    n_vec++;
    if (fs_count !== 1) begin
      $display("FAIL frame_start_count got %0d want 1", fs_count);
      n_err++;
    end
  endtask

  // Frame 2 with color held at 3'b111: blanking must still force rgb to 0.
  task automatic test_blanking_gate();
    obs_t exp, got;
    int   de_count = 0;
    white = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge CLOCK_25);
      @(negedge CLOCK_25);
      cyc++;
      got = sample();
      model_step(1'b1, 1'b0, exp);
      n_vec++;
      if (got !== exp) begin
        report("blanking_gate", got, exp);
        n_err++;
      end
      if (got.de) de_count++;
      if (i == 0) begin
        n_vec++;
        if (got.frame_start !== 1'b1 || cyc !== FRAME + 1) begin
          $display("FAIL frame_period got fs=%0b at cyc %0d want 1 at %0d",
                   got.frame_start, cyc, FRAME + 1);
          n_err++;
        end
      end
    end
    n_vec++;
    if (de_count !== HA * VA) begin
      $display("FAIL de_count got %0d want %0d", de_count, HA * VA);
      n_err++;
    end
  endtask

  task automatic test_mid_frame_reset();
    obs_t exp, got, rst_exp;
    int   budget = 0;
    rst_exp = '{rgb: 3'd0, de: 1'b0, hsync: 1'b1, vsync: 1'b1, frame_start: 1'b0,
                x: 12'd1, y: 12'd1};
    white = 1'b0;
    while (!(hm == 700 && vm == VA + VF + 1) && budget < 2 * FRAME) begin
      @(posedge CLOCK_25);
      @(negedge CLOCK_25);
      cyc++;
      budget++;
      got = sample();
      model_step(1'b0, 1'b0, exp);
      n_vec++;
      if (got !== exp) begin
        report("pre_reset", got, exp);
        n_err++;
      end
    end
    n_vec++;
    if (vsync !== 1'b0 || budget >= 2 * FRAME) begin
      $display("FAIL vsync_before_reset got %0b want 0 (budget %0d)", vsync, budget);
      n_err++;
    end
    #5 reset = 1'b1;
    #1;
    got = sample();
    n_vec++;
    if (got !== rst_exp) begin
      report("async_reset", got, rst_exp);
      n_err++;
    end
    repeat (2) @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    reset = 1'b0;
    hm = 0; vm = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLOCK_25);
      @(negedge CLOCK_25);
      got = sample();
      model_step(1'b0, 1'b0, exp);
      n_vec++;
      if (got !== exp) begin
        report("after_release", got, exp);
        n_err++;
      end
      if (i == 0) begin
        n_vec++;
        if (got.frame_start !== 1'b1) begin
          $display("FAIL first_frame_start got %0b want 1", got.frame_start);
          n_err++;
        end
      end
    end
  endtask

  // With the feature built in, bars follow h_cnt[8:6]; otherwise the
  // select is ignored and rgb follows color.
  task automatic test_pattern_bars();
    obs_t exp, got;
    white = 1'b0;
    test_pattern = 1'b1;
    for (int i = 0; i < 2 * HT; i++) begin
      @(posedge CLOCK_25);
      @(negedge CLOCK_25);
      got = sample();
      model_step(1'b0, 1'b1, exp);
      n_vec++;
      if (got !== exp) begin
        report("test_pattern", got, exp);
        n_err++;
      end
    end
    test_pattern = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    white        = 1'b0;
    test_pattern = 1'b0;
    test_reset();
    test_timing_colour();
    test_blanking_gate();
    test_mid_frame_reset();
    test_pattern_bars();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates 640x480 @ 60 Hz VGA timing from the 25 MHz pixel clock and is the consumer side of the pixel interface: it drives the 1-based `x`/`y` coordinates into the image generator and registers the returned 3-bit `color` onto the VGA pins. It sits between the board top level and `img_generator`. Sync, data-enable and colour outputs leave the block aligned to one another.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FRONT`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync pulse width, in pixels.
- `H_BACK`, default 48: horizontal back porch, in pixels.
- `V_ACTIVE`, default 480: visible lines.
- `V_FRONT`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync width, in lines.
- `V_BACK`, default 33: vertical back porch, in lines.

Ports:
- `CLOCK_25` in 1: pixel clock. This is the block's only clock.
- `reset` in 1: reset, asynchronous and active-high.
- `color` in 3: pixel colour from the image generator, driven combinationally from `x`/`y`.
- `test_pattern` in 1: selects the built-in colour bars. Only has an effect with `VGA_TEST_PATTERN_EN`.
- `x` out 12: 1..640 during active video, 0 during blanking.
- `y` out 12: 1..480 during active lines, 0 during blanking.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `de` out 1: data enable, aligned with `rgb`.
- `rgb` out 3: pixel output to the DAC or pins.
- `frame_start` out 1: one-cycle pulse on the first active pixel of each frame, aligned with `rgb`.

## Operation
- **Stage 0 counters.**
  - `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = 800.
  - `v_cnt` counts 0..V_TOTAL-1, where V_TOTAL = 525. It increments when `h_cnt` wraps from 799 to 0.
  - `v_cnt` wraps from 524 to 0 on the same edge that `h_cnt` wraps.
- **Active region.**
  - `act0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)`.
  - `x = act0 ? h_cnt+1 : 0` and `y = act0 ? v_cnt+1 : 0`. Both are decoded combinationally from the registered counters and zero-extended to 12 bits.
- **Sync windows.**
  - `hs0` is low for `H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC`, i.e. 656..751.
  - `vs0` is low for lines 490..491.
- **Stage 1 output registers.**
  - `hsync <= hs0`, `vsync <= vs0`, `de <= act0`.
  - `rgb <= act0 ? color : 3'b000`. `rgb` is forced to 0 in blanking regardless of `color`.
  - `frame_start <= (h_cnt==0 && v_cnt==0)`.
- **Counter widths.** 10 bits each; arithmetic never exceeds 799.
- **Reset.** Asynchronous assert, with the outputs below held for the whole of reset:
  - counters 0, so `x`=1, `y`=1;
  - `hsync`=1, `vsync`=1, `de`=0, `rgb`=0, `frame_start`=0.
- **Reset mid-frame.** Counters restart at 0,0. The first stage-1 outputs after release belong to pixel (1,1). No partial sync pulse is extended.

## Timing
- **Pixel latency.** Exactly one cycle from `x`/`y` to `rgb`/`de`/`hsync`/`vsync`. `color` is sampled on the edge that ends the cycle in which `x`/`y` are presented.
- **Frame length.** 800×525 = 420000 cycles, giving 59.52 Hz at 25 MHz.
- **`frame_start`.** Asserted once per frame, for exactly 1 cycle, coinciding with `rgb` for pixel (1,1).
- **Pulse widths.** `hsync` low for 96 consecutive cycles per line; `vsync` low for 1600 consecutive cycles per frame.
- **Sync polarity.** Both sync outputs are negative.
- **First cycle after reset deassertion.** Stage-1 outputs reflect counter state 0,0.

## Configuration
- `VGA_TEST_PATTERN_EN` defined: when `test_pattern`=1, stage 1 replaces `color` with `h_cnt[8:6]`. This gives eight 64-pixel bars repeating across the line. Blanking still forces 0.
- `VGA_TEST_PATTERN_EN` undefined: `test_pattern` is ignored and no mux is synthesised. `rgb` is always the gated `color`.

## Structure
- **Shared header.** H/V totals and porch values belong in `global_symbols.vh`, next to `FRAME_WIDTH`/`FRAME_HEIGHT`. `FRAME_WIDTH` must equal `H_ACTIVE` and `FRAME_HEIGHT` must equal `V_ACTIVE`.
- **Sub-module `vga_axis_counter`.**
  - Parameters: total, active, front porch, sync width.
  - Inputs: `CLOCK_25`, `reset`, `inc`.
  - Outputs: `cnt`, `active`, `sync_n`, `wrap`.
  - Instantiated twice. The horizontal instance has `inc`=1. The vertical instance is driven by the horizontal `wrap`.

## Test plan
- **Reset defaults.** Hold `reset` 5 cycles → `hsync`=1, `vsync`=1, `de`=0, `rgb`=0, `x`=1, `y`=1 throughout.
- **Frame measurement.** Release reset and run 2 frames, counting cycles → `frame_start` pulses exactly 420000 cycles apart. Per line: `hsync` low for 96 cycles, starting 656 cycles after `de` first rises. `vsync` low for 1600 cycles per frame.
- **Colour path.** Drive `color = x[2:0]` → on line 1, `rgb` sequence is 1,2,…,7,0,1… one cycle after each `x`. `rgb`=0 and `de`=0 for all 160 blanking cycles.
- **Blanking gate.** Drive `color`=3'b111 constantly → `rgb` is 0 whenever `x`==0 or `y`==0, one cycle later. `de` count per frame is exactly 307200.
- **Reset mid-frame.** Assert `reset` at `h_cnt`=700, `v_cnt`=491 (inside vsync) → `vsync` returns to 1 immediately and asynchronously. After release, next `frame_start` occurs 1 cycle later.
- **Test pattern.** With `VGA_TEST_PATTERN_EN` defined and `test_pattern`=1 → `rgb` = 0 for `x` 1..64, 1 for `x` 65..128, …, 7 for `x` 449..512, 0 for `x` 513..576. Undefined → `test_pattern` has no effect.
